// File: rtl/eyeriss_seq.sv
// rtl/eyeriss_seq.sv - job sequencer for a systolic MAC array: clear, accumulate, then drain row-0 outputs as valid/ready beats
module eyeriss_seq #(
    parameter int HEIGHT = 12,
    parameter int WIDTH  = 14,
    parameter int OWIDTH = 24,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CWIDTH-1:0] mac_cycles,
    output logic              busy,
    output logic              done,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [HEIGHT-1:0] mac_done,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o,
    input  logic [OWIDTH-1:0] ofm [WIDTH],
    output logic [OWIDTH-1:0] res [WIDTH],
    output logic              res_vld,
    input  logic              res_rdy
);

    localparam int BW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        MAC,
        MDONE,
        DRAIN,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CWIDTH-1:0] n_q, n_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic              done_q, done_d;
    logic              res_vld_q, res_vld_d;
    logic [OWIDTH-1:0] res_q [WIDTH];
    logic              shift;
    logic              load;

    // A beat can advance whenever the output register is empty or being consumed.
    assign shift = !res_vld_q || res_rdy;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = (mac_cycles == '0) ? CWIDTH'(1) : mac_cycles;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                // Compare against N-1 so N = 2^CWIDTH-1 never needs a wider counter.
                if (cnt_q == n_q - CWIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = MDONE;
                end else begin
                    cnt_d = cnt_q + CWIDTH'(1);
                end
            end
            MDONE: begin
                beat_d  = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (shift) begin
                    load   = 1'b1;
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(HEIGHT - 1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                if (shift) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            res_vld_d = 1'b1;
        end else if (res_vld_q && res_rdy) begin
            res_vld_d = 1'b0;
        end else begin
            res_vld_d = res_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            cnt_q     <= '0;
            beat_q    <= '0;
            done_q    <= 1'b0;
            res_vld_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            res_vld_q <= res_vld_d;
            if (load) begin
                res_q <= ofm;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign clr_i    = {HEIGHT{state_q == CLR}};
    assign clr_w    = {WIDTH{state_q == CLR}};
    assign clr_o    = {WIDTH{state_q == CLR}};
    assign en_i     = {HEIGHT{state_q == MAC}};
    assign en_w     = {WIDTH{state_q == MAC}};
    assign mac_done = {HEIGHT{state_q == MDONE}};
    // en_o follows the handshake combinationally; rst_n gates it while reset is held.
    assign en_o     = {WIDTH{rst_n && (state_q == DRAIN) && shift}};
    assign res      = res_q;
    assign res_vld  = res_vld_q;

endmodule

// File: tb/tb_eyeriss_seq.sv
// tb/tb_eyeriss_seq.sv - scoreboard bench for eyeriss_seq with a behavioural array driving ofm
module tb_eyeriss_seq;

    localparam int H  = 12;
    localparam int W  = 14;
    localparam int OW = 24;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] mac_cycles;
    logic          busy, done;
    logic [H-1:0]  en_i, clr_i, mac_done;
    logic [W-1:0]  en_w, clr_w, en_o, clr_o;
    logic [OW-1:0] ofm [W];
    logic [OW-1:0] res [W];
    logic          res_vld;
    logic          res_rdy;

    always #5 clk = ~clk;

    eyeriss_seq #(.HEIGHT(H), .WIDTH(W), .OWIDTH(OW), .CWIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mac_cycles(mac_cycles),
        .busy(busy), .done(done), .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done),
        .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
        .ofm(ofm), .res(res), .res_vld(res_vld), .res_rdy(res_rdy)
    );

    int n_tests = 0, n_fail = 0, sb_tests = 0, sb_fail = 0;
    int job_id = 0, seen_job = 0, mdl_job = 0, k_cnt = 0;
    bit shift_pend = 1'b0;
    int cyc = 0;
    int n_busy = 0, n_clr = 0, n_eni = 0, n_enw = 0, n_md = 0, n_done = 0, n_beats = 0;
    int done_cyc = 0, last_pop_cyc = 0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] saved [W];

    function automatic logic [OW-1:0] ofm_word(input int job, input int k, input int c);
        return {job[7:0], k[7:0], c[7:0]};
    endfunction

    // Array model: row-0 output advances by one row each time en_o was seen high.
    always @(negedge clk) begin
        if (job_id != mdl_job) begin
            mdl_job    = job_id;
            k_cnt      = 0;
            shift_pend = 1'b0;
        end
        if (shift_pend) k_cnt++;
        shift_pend = rst_n && (en_o != '0);
        for (int c = 0; c < W; c++) ofm[c] = ofm_word(job_id, k_cnt, c);
    end

    // Monitor: per-job activity counters and scoreboard pops on each handshake.
    always @(negedge clk) begin
        if (job_id != seen_job) begin
            seen_job = job_id;
            n_busy = 0; n_clr = 0; n_eni = 0; n_enw = 0; n_md = 0; n_done = 0; n_beats = 0;
        end
        if (rst_n) begin
            cyc++;
            if (busy) n_busy++;
            if ((&clr_i) && (&clr_w) && (&clr_o)) n_clr++;
            if (&en_i) n_eni++;
            if (&en_w) n_enw++;
            if (&mac_done) n_md++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (en_o != '0 && en_o != '1) begin
                sb_fail++;
                $display("FAIL en_o_uniform: got %h required all-0 or all-1", en_o);
            end
            if (res_vld && res_rdy) begin
                sb_tests++;
                if (exp_q.size() < W) begin
                    sb_fail++;
                    $display("FAIL beat_unexpected: got beat %h.. required none queued", res[0]);
                end else begin
                    bit bad = 1'b0;
                    for (int c = 0; c < W; c++) begin
                        logic [OW-1:0] e;
                        e = exp_q.pop_front();
                        if (res[c] !== e) begin
                            if (!bad) $display("FAIL beat%0d_col%0d: got %h required %h", n_beats, c, res[c], e);
                            bad = 1'b1;
                        end
                    end
                    if (bad) sb_fail++;
                end
                n_beats++;
                last_pop_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the CLR cycle.
    task automatic start_job(input int mac);
        job_id++;
        for (int k = 0; k < H; k++)
            for (int c = 0; c < W; c++) exp_q.push_back(ofm_word(job_id, k, c));
        start      = 1'b1;
        mac_cycles = CW'(mac);
        @(posedge clk); #1;
        start      = 1'b0;
        mac_cycles = '0;
    endtask

    // Returns at posedge+1 of the cycle after the done pulse.
    task automatic wait_done();
        int t = 0;
        while (!done && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("done_seen", done, 1);
        @(negedge clk); #1;
        @(posedge clk); #1;
        chk("done_width", done, 0);
    endtask

    task automatic wait_vld();
        int t = 0;
        while (!res_vld && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("res_vld_seen", res_vld, 1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        bit bad = 1'b0;
        for (int c = 0; c < W; c++) if (res[c] !== '0) bad = 1'b1;
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_res_vld"}, res_vld, 0);
        chk({nm, "_row_ctl"}, {en_i, clr_i, mac_done}, 0);
        chk({nm, "_col_ctl"}, {en_w, clr_w, en_o, clr_o}, 0);
        chk({nm, "_res_zero"}, bad, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        mac_cycles = '0;
        res_rdy    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic job, N=3
        start_job(3);
        wait_done();
        chk("a_clr_cycles", n_clr, 1);
        chk("a_en_i_cycles", n_eni, 3);
        chk("a_en_w_cycles", n_enw, 3);
        chk("a_mac_done_cycles", n_md, 1);
        chk("a_beats", n_beats, 12);
        chk("a_done_count", n_done, 1);
        chk("a_done_after_last_beat", done_cyc - last_pop_cyc, 1);
        chk("a_busy_cycles", n_busy, 18);
        chk("a_queue_empty", exp_q.size(), 0);

        // mac_cycles=0 behaves as N=1, started the cycle after done
        start_job(0);
        wait_done();
        chk("b_en_i_cycles", n_eni, 1);
        chk("b_busy_cycles", n_busy, 16);
        chk("b_beats", n_beats, 12);

        // Back-pressure: hold res_rdy low for 5 cycles mid-drain
        start_job(3);
        wait_vld();
        res_rdy = 1'b0;
        for (int c = 0; c < W; c++) saved[c] = res[c];
        for (int i = 0; i < 5; i++) begin
            bit moved = 1'b0;
            @(negedge clk);
            for (int c = 0; c < W; c++) if (res[c] !== saved[c]) moved = 1'b1;
            chk("c_stall_en_o", en_o, 0);
            chk("c_stall_res_stable", moved, 0);
            chk("c_stall_res_vld", res_vld, 1);
            @(posedge clk); #1;
        end
        res_rdy = 1'b1;
        wait_done();
        chk("c_beats", n_beats, 12);
        chk("c_busy_cycles", n_busy, 23);
        chk("c_queue_empty", exp_q.size(), 0);

        // start pulsed during MAC is ignored
        start_job(8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start      = 1'b1;
        mac_cycles = 8'd2;
        @(posedge clk); #1;
        start      = 1'b0;
        mac_cycles = '0;
        chk("d_still_mac", en_i, 12'hFFF);
        wait_done();
        chk("d_en_i_cycles", n_eni, 8);
        chk("d_done_count", n_done, 1);
        chk("d_busy_cycles", n_busy, 23);
        chk("d_beats", n_beats, 12);

        // Reset for one cycle in the middle of DRAIN
        start_job(2);
        wait_vld();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_en_o_in_reset", en_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk_idle_outputs("e_after_reset");
        @(posedge clk); #1;
        start_job(2);
        wait_done();
        chk("e_en_i_cycles", n_eni, 2);
        chk("e_beats", n_beats, 12);
        chk("e_busy_cycles", n_busy, 17);

        // Largest N
        start_job(255);
        wait_done();
        chk("f_en_i_cycles", n_eni, 255);
        chk("f_busy_cycles", n_busy, 270);
        chk("f_beats", n_beats, 12);
        chk("f_done_count", n_done, 1);
        chk("f_queue_empty", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        n_tests += sb_tests;
        n_fail  += sb_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
